// File: rtl/sliced_counter_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sliced_counter_arb: shared counter with round-robin arbitrated increment |
// | requests and per-port bit-slice views.                  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module sliced_counter_arb #(
  parameter int                 WIDTH    = 5,
  parameter int                 PORTS    = 3,
  parameter int                 SLICE_W  = 2,
  parameter logic [PORTS*8-1:0] OFFSETS  = 24'h03_01_00,
  parameter bit                 SATURATE = 1'b0,
  parameter logic [WIDTH-1:0]   INIT     = '0,
  localparam int                IDW      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic [PORTS-1:0]         req_i,
  input  logic [PORTS*32-1:0]      arg_i,
  output logic [PORTS-1:0]         ack_o,
  output logic [IDW-1:0]           last_id_o,
  output logic [31:0]              last_arg_o,
  output logic [WIDTH-1:0]         x_o,
  output logic [PORTS*SLICE_W-1:0] view_o,
  output logic                     ovf_o
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [PORTS-1:0] ack_q, ack_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [31:0]      last_arg_q, last_arg_d;
  logic             ovf_q, ovf_d;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;

  // First requester at or after ptr, scanning upward modulo PORTS.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_found && req_i[(int'(ptr_q) + i) % PORTS]) begin
        w_found = 1'b1;
        w_gnt   = IDW'((int'(ptr_q) + i) % PORTS);
      end
    end
  end

  always_comb begin
    x_d        = x_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    last_id_d  = last_id_q;
    last_arg_d = last_arg_q;
    ovf_d      = ovf_q;
    if (clr_i) begin
      x_d   = INIT;
      ovf_d = 1'b0;
    end else if (w_found) begin
      ack_d[w_gnt] = 1'b1;
      last_id_d    = w_gnt;
      last_arg_d   = arg_i[int'(w_gnt)*32 +: 32];
      ptr_d        = (w_gnt == IDW'(PORTS - 1)) ? '0 : w_gnt + 1'b1;
      if (&x_q) begin
        ovf_d = 1'b1;
        x_d   = SATURATE ? x_q : '0;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q        <= INIT;
      ptr_q      <= '0;
      ack_q      <= '0;
      last_id_q  <= '0;
      last_arg_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      last_id_q  <= last_id_d;
      last_arg_q <= last_arg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign x_o        = x_q;
  assign ack_o      = ack_q;
  assign last_id_o  = last_id_q;
  assign last_arg_o = last_arg_q;
  assign ovf_o      = ovf_q;

  generate
    for (genvar p = 0; p < PORTS; p++) begin : g_view
      assign view_o[p*SLICE_W +: SLICE_W] = x_q[OFFSETS[8*p +: 8] +: SLICE_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sliced_counter_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sliced_counter_arb: directed self-checking bench for the counter arb. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sliced_counter_arb;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [2:0]  req;
  logic [95:0] arg;
  logic [3:0]  req_c;
  logic [127:0] arg_c;

  logic [2:0]  ack_a, ack_b;
  logic [1:0]  lid_a, lid_b;
  logic [31:0] larg_a, larg_b;
  logic [4:0]  x_a, x_b;
  logic [5:0]  view_a, view_b;
  logic        ovf_a, ovf_b;

  logic [3:0]  ack_c;
  logic [1:0]  lid_c;
  logic [31:0] larg_c;
  logic [7:0]  x_c;
  logic [11:0] view_c;
  logic        ovf_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sliced_counter_arb dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_i(req), .arg_i(arg),
    .ack_o(ack_a), .last_id_o(lid_a), .last_arg_o(larg_a), .x_o(x_a),
    .view_o(view_a), .ovf_o(ovf_a)
  );

  sliced_counter_arb #(.SATURATE(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_i(req), .arg_i(arg),
    .ack_o(ack_b), .last_id_o(lid_b), .last_arg_o(larg_b), .x_o(x_b),
    .view_o(view_b), .ovf_o(ovf_b)
  );

  sliced_counter_arb #(.WIDTH(8), .PORTS(4), .SLICE_W(3), .OFFSETS(32'h05_04_02_00)) dut_c (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_i(req_c), .arg_i(arg_c),
    .ack_o(ack_c), .last_id_o(lid_c), .last_arg_o(larg_c), .x_o(x_c),
    .view_o(view_c), .ovf_o(ovf_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (x_a !== 5'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_a); end
    checks++; if (ack_a !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b exp=000", ack_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    checks++; if (lid_a !== 2'd0) begin failures++; $display("FAIL reset_last_id got=%0d exp=0", lid_a); end
    checks++; if (larg_a !== 32'd0) begin failures++; $display("FAIL reset_last_arg got=%0h exp=0", larg_a); end
    checks++; if (view_a !== 6'd0) begin failures++; $display("FAIL reset_view got=%b exp=0", view_a); end
  endtask

  task automatic test_single_port();
    logic [4:0] exp_x [3]  = '{5'd1, 5'd2, 5'd3};
    logic [1:0] exp_v0 [3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] exp_v1 [3] = '{2'b00, 2'b01, 2'b01};
    arg[31:0] = 32'd7;
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ack_a !== 3'b001) begin failures++; $display("FAIL single_ack[%0d] got=%b exp=001", i, ack_a); end
      checks++; if (x_a !== exp_x[i]) begin failures++; $display("FAIL single_x[%0d] got=%0d exp=%0d", i, x_a, exp_x[i]); end
      checks++; if (view_a[1:0] !== exp_v0[i]) begin failures++; $display("FAIL single_view0[%0d] got=%b exp=%b", i, view_a[1:0], exp_v0[i]); end
      checks++; if (view_a[3:2] !== exp_v1[i]) begin failures++; $display("FAIL single_view1[%0d] got=%b exp=%b", i, view_a[3:2], exp_v1[i]); end
      checks++; if (larg_a !== 32'd7) begin failures++; $display("FAIL single_last_arg[%0d] got=%0d exp=7", i, larg_a); end
    end
    req = 3'b000;
    tick();
    checks++; if (ack_a !== 3'b000) begin failures++; $display("FAIL idle_ack got=%b exp=000", ack_a); end
    checks++; if (x_a !== 5'd3) begin failures++; $display("FAIL idle_x got=%0d exp=3", x_a); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_ack [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0] exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    pulse_reset();
    arg = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ack_a !== exp_ack[i]) begin failures++; $display("FAIL cont_ack[%0d] got=%b exp=%b", i, ack_a, exp_ack[i]); end
      checks++; if (lid_a !== exp_id[i]) begin failures++; $display("FAIL cont_last_id[%0d] got=%0d exp=%0d", i, lid_a, exp_id[i]); end
      checks++; if (x_a !== 5'(i + 1)) begin failures++; $display("FAIL cont_x[%0d] got=%0d exp=%0d", i, x_a, i + 1); end
    end
    checks++; if (larg_a !== 32'hCCCC_0002) begin failures++; $display("FAIL cont_last_arg got=%0h exp=cccc0002", larg_a); end
    checks++; if (view_a[5:4] !== 2'b00) begin failures++; $display("FAIL cont_view2 got=%b exp=00", view_a[5:4]); end
    checks++; if (view_a[3:2] !== 2'b11) begin failures++; $display("FAIL cont_view1 got=%b exp=11", view_a[3:2]); end
    req = 3'b000;
  endtask

  task automatic test_clear_vs_req();
    pulse_reset();
    req = 3'b001;
    repeat (5) tick();
    checks++; if (x_a !== 5'd5) begin failures++; $display("FAIL clr_pre_x got=%0d exp=5", x_a); end
    clr = 1'b1;
    req = 3'b011;
    tick();
    checks++; if (ack_a !== 3'b000) begin failures++; $display("FAIL clr_ack got=%b exp=000", ack_a); end
    checks++; if (x_a !== 5'd0) begin failures++; $display("FAIL clr_x got=%0d exp=0", x_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", ovf_a); end
    checks++; if (lid_a !== 2'd0) begin failures++; $display("FAIL clr_last_id got=%0d exp=0", lid_a); end
    clr = 1'b0;
    tick();
    checks++; if (ack_a !== 3'b010) begin failures++; $display("FAIL post_clr_ack got=%b exp=010", ack_a); end
    checks++; if (x_a !== 5'd1) begin failures++; $display("FAIL post_clr_x got=%0d exp=1", x_a); end
    checks++; if (lid_a !== 2'd1) begin failures++; $display("FAIL post_clr_last_id got=%0d exp=1", lid_a); end
    req = 3'b000;
  endtask

  task automatic test_wrap();
    int acks = 0;
    pulse_reset();
    req = 3'b001;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (ack_a === 3'b001) acks++;
    end
    checks++; if (acks !== 31) begin failures++; $display("FAIL wrap_b2b_acks got=%0d exp=31", acks); end
    checks++; if (x_a !== 5'd31) begin failures++; $display("FAIL wrap_pre_x got=%0d exp=31", x_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL wrap_pre_ovf got=%b exp=0", ovf_a); end
    tick();
    req = 3'b000;
    checks++; if (x_a !== 5'd0) begin failures++; $display("FAIL wrap_x got=%0d exp=0", x_a); end
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%b exp=1", ovf_a); end
    checks++; if (ack_a !== 3'b001) begin failures++; $display("FAIL wrap_ack got=%b exp=001", ack_a); end
    checks++; if (x_b !== 5'd31) begin failures++; $display("FAIL sat_x got=%0d exp=31", x_b); end
    checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", ovf_b); end
    checks++; if (ack_b !== 3'b001) begin failures++; $display("FAIL sat_ack got=%b exp=001", ack_b); end
    repeat (3) tick();
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL wrap_ovf_sticky got=%b exp=1", ovf_a); end
    checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky got=%b exp=1", ovf_b); end
    checks++; if (ack_a !== 3'b000) begin failures++; $display("FAIL wrap_idle_ack got=%b exp=000", ack_a); end
    checks++; if (x_a !== 5'd0) begin failures++; $display("FAIL wrap_idle_x got=%0d exp=0", x_a); end
  endtask

  task automatic test_reset_mid();
    req = 3'b010;
    repeat (9) tick();
    checks++; if (x_a !== 5'd9) begin failures++; $display("FAIL rmid_pre_x got=%0d exp=9", x_a); end
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL rmid_pre_ovf got=%b exp=1", ovf_a); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (x_a !== 5'd0) begin failures++; $display("FAIL rmid_x got=%0d exp=0", x_a); end
    checks++; if (view_a !== 6'd0) begin failures++; $display("FAIL rmid_view got=%b exp=0", view_a); end
    checks++; if (ack_a !== 3'b000) begin failures++; $display("FAIL rmid_ack got=%b exp=000", ack_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", ovf_a); end
    checks++; if (x_b !== 5'd0) begin failures++; $display("FAIL rmid_sat_x got=%0d exp=0", x_b); end
    req = 3'b111;
    #1;
    rst = 1'b0;
    tick();
    checks++; if (ack_a !== 3'b001) begin failures++; $display("FAIL rmid_prio_ack got=%b exp=001", ack_a); end
    checks++; if (lid_a !== 2'd0) begin failures++; $display("FAIL rmid_prio_id got=%0d exp=0", lid_a); end
    req = 3'b000;
  endtask

  task automatic test_params();
    int cnt [4] = '{0, 0, 0, 0};
    int bad_onehot = 0;
    pulse_reset();
    req_c = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!$onehot(ack_c)) bad_onehot++;
      for (int p = 0; p < 4; p++) if (ack_c[p] === 1'b1) cnt[p]++;
    end
    req_c = 4'b0000;
    checks++; if (bad_onehot !== 0) begin failures++; $display("FAIL par_onehot got=%0d bad exp=0", bad_onehot); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (cnt[p] !== 10) begin failures++; $display("FAIL par_acks[%0d] got=%0d exp=10", p, cnt[p]); end
    end
    checks++; if (x_c !== 8'd40) begin failures++; $display("FAIL par_x got=%0d exp=40", x_c); end
    checks++; if (view_c[11:9] !== 3'b001) begin failures++; $display("FAIL par_view3 got=%b exp=001", view_c[11:9]); end
    checks++; if (view_c[2:0] !== 3'b000) begin failures++; $display("FAIL par_view0 got=%b exp=000", view_c[2:0]); end
    checks++; if (ovf_c !== 1'b0) begin failures++; $display("FAIL par_ovf got=%b exp=0", ovf_c); end
  endtask

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    req   = '0;
    arg   = '0;
    req_c = '0;
    arg_c = {32'd3, 32'd2, 32'd1, 32'd0};
    repeat (2) tick();
    test_reset();
    rst = 1'b0;
    test_single_port();
    test_contention();
    test_clear_vs_req();
    test_wrap();
    test_reset_mid();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
